// File: rtl/ahblsram_port_arbiter_pkg.sv
// Shared types for the two-requester SRAM port arbiter: requester ids, FSM
// states, read-return tags and width/legal-range constants.
package ahblsram_port_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned LOCK_CNT_W = 8;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    REQ_0    = 2'd0,
    REQ_1    = 2'd1,
    REQ_NONE = 2'd3
  } req_id_e;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Lock state that keeps the given requester as owner.
  function automatic arb_state_e own_state(input req_id_e id);
    return (id == REQ_1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/ahblsram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the shared port, bundled for the arbiter.
interface ahblsram_port_arbiter_if #(
  parameter int unsigned MEM_AWIDTH = 16
) ();
  import ahblsram_port_arbiter_pkg::*;

  logic                  req0, req1;
  logic                  lock0, lock1;
  logic                  we0, we1;
  logic [MEM_AWIDTH-1:0] addr0, addr1;
  logic [BE_W-1:0]       byteen0, byteen1;
  logic [DATA_W-1:0]     wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_W-1:0]     rdata0, rdata1;
  logic                  mem_ren, mem_wen;
  logic [MEM_AWIDTH-1:0] mem_addr;
  logic [BE_W-1:0]       mem_byteen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1,
           byteen0, byteen1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1,
           byteen0, byteen1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );

endinterface

// File: rtl/ahblsram_rd_tag_pipe.sv
// DEPTH-stage shift register carrying read-return tags, with synchronous clear.
module ahblsram_rd_tag_pipe
  import ahblsram_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ahblsram_port_arbiter.sv
// Round-robin arbiter with bounded lock sharing one SRAM port between two
// requesters; read data is routed back by a fixed-latency tag pipe.
module ahblsram_port_arbiter
  import ahblsram_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_LOCK   = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  ahblsram_port_arbiter_if.slave arb_if
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("RD_LAT must be 1 or 2");
  end
  if (MAX_LOCK < 1 || MAX_LOCK > 255) begin : g_bad_max_lock
    $error("MAX_LOCK must be in 1..255");
  end

  arb_state_e              state_q, state_d;
  logic                    last_win_q, last_win_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [LOCK_CNT_W-1:0]   lock_base_c;
  logic [LOCK_CNT_W:0]     lock_next_c;

  req_id_e                 win_id_c;
  logic                    win_valid_c, win_sel_c, win_we_c, win_lock_c;
  logic [MEM_AWIDTH-1:0]   win_addr_c;
  logic [BE_W-1:0]         win_be_c;
  logic [DATA_W-1:0]       win_wdata_c;
  rd_tag_t                 tag_in_c, tag_out;

  // Winner: owner keeps the port while requesting, otherwise round-robin.
  always_comb begin
    win_id_c = REQ_NONE;
    if (!HRESETN)                                 win_id_c = REQ_NONE;
    else if (state_q == ST_OWN0 && arb_if.req0)   win_id_c = REQ_0;
    else if (state_q == ST_OWN1 && arb_if.req1)   win_id_c = REQ_1;
    else if (arb_if.req0 && arb_if.req1)          win_id_c = last_win_q ? REQ_0 : REQ_1;
    else if (arb_if.req0)                         win_id_c = REQ_0;
    else if (arb_if.req1)                         win_id_c = REQ_1;
  end

  assign win_valid_c = (win_id_c != REQ_NONE);
  assign win_sel_c   = (win_id_c == REQ_1);
  assign win_we_c    = win_sel_c ? arb_if.we1     : arb_if.we0;
  assign win_lock_c  = win_sel_c ? arb_if.lock1   : arb_if.lock0;
  assign win_addr_c  = win_sel_c ? arb_if.addr1   : arb_if.addr0;
  assign win_be_c    = win_sel_c ? arb_if.byteen1 : arb_if.byteen0;
  assign win_wdata_c = win_sel_c ? arb_if.wdata1  : arb_if.wdata0;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q    <= ST_FREE;
      last_win_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock count restarts when a different requester takes over the port.
  always_comb begin
    state_d     = ST_FREE;
    last_win_d  = last_win_q;
    lock_cnt_d  = '0;
    lock_base_c = '0;
    if (win_valid_c && state_q == own_state(win_id_c)) lock_base_c = lock_cnt_q;
    lock_next_c = {1'b0, lock_base_c} + (LOCK_CNT_W+1)'(1);
    if (win_valid_c) begin
      last_win_d = win_sel_c;
      if (win_lock_c && lock_next_c < (LOCK_CNT_W+1)'(MAX_LOCK)) begin
        state_d    = own_state(win_id_c);
        lock_cnt_d = lock_next_c[LOCK_CNT_W-1:0];
      end
    end
  end

  always_comb begin
    arb_if.gnt0       = win_valid_c & ~win_sel_c;
    arb_if.gnt1       = win_valid_c &  win_sel_c;
    arb_if.mem_ren    = 1'b0;
    arb_if.mem_wen    = 1'b0;
    arb_if.mem_addr   = '0;
    arb_if.mem_byteen = '0;
    arb_if.mem_wdata  = '0;
    if (win_valid_c) begin
      arb_if.mem_ren    = ~win_we_c;
      arb_if.mem_wen    =  win_we_c;
      arb_if.mem_addr   = win_addr_c;
      arb_if.mem_byteen = win_we_c ? win_be_c : {BE_W{1'b1}};
      arb_if.mem_wdata  = win_wdata_c;
    end
  end

  assign tag_in_c = '{valid: win_valid_c & ~win_we_c, id: win_sel_c};

  ahblsram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk_i (HCLK),
    .clr_i (~HRESETN),
    .tag_i (tag_in_c),
    .tag_o (tag_out)
  );

  assign arb_if.rvalid0 = HRESETN & tag_out.valid & ~tag_out.id;
  assign arb_if.rvalid1 = HRESETN & tag_out.valid &  tag_out.id;
  assign arb_if.rdata0  = arb_if.mem_rdata;
  assign arb_if.rdata1  = arb_if.mem_rdata;

endmodule

// File: tb/tb_ahblsram_port_arbiter.sv
// Bench for ahblsram_port_arbiter: two instances (RD_LAT 1 and 2, MAX_LOCK 3)
// share stimulus; read returns are checked against a scoreboard queue.
module tb_ahblsram_port_arbiter;
  import ahblsram_port_arbiter_pkg::*;

  localparam int unsigned AW   = 16;
  localparam int unsigned MAXL = 3;

  typedef struct {
    int unsigned due;
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ahblsram_port_arbiter_if #(.MEM_AWIDTH(AW)) if_a ();
  ahblsram_port_arbiter_if #(.MEM_AWIDTH(AW)) if_b ();

  ahblsram_port_arbiter #(.MEM_AWIDTH(AW), .RD_LAT(1), .MAX_LOCK(MAXL)) dut_a (
    .HCLK(clk), .HRESETN(rst_n), .arb_if(if_a)
  );
  ahblsram_port_arbiter #(.MEM_AWIDTH(AW), .RD_LAT(2), .MAX_LOCK(MAXL)) dut_b (
    .HCLK(clk), .HRESETN(rst_n), .arb_if(if_b)
  );

  function automatic logic [31:0] pattern(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  // SRAM stubs: read data appears RD_LAT cycles after mem_ren.
  logic [31:0] a_pipe;
  logic [31:0] b_pipe0, b_pipe1;
  always @(posedge clk) begin
    a_pipe  <= if_a.mem_ren ? pattern(if_a.mem_addr) : 32'h0;
    b_pipe0 <= if_b.mem_ren ? pattern(if_b.mem_addr) : 32'h0;
    b_pipe1 <= b_pipe0;
  end
  assign if_a.mem_rdata = a_pipe;
  assign if_b.mem_rdata = b_pipe1;

  // Read-return monitor: pops the scoreboard when an entry falls due.
  logic [1:0]  mon_v;
  logic [31:0] mon_d0, mon_d1;
  exp_t        mon_e;
  bit          mon_due;
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      mon_due = 1'b0;
      if (d == 0) begin
        mon_v  = {if_a.rvalid1, if_a.rvalid0};
        mon_d0 = if_a.rdata0;
        mon_d1 = if_a.rdata1;
        if (q_a.size() > 0) if (q_a[0].due == cyc) begin
          mon_due = 1'b1;
          mon_e   = q_a.pop_front();
        end
      end else begin
        mon_v  = {if_b.rvalid1, if_b.rvalid0};
        mon_d0 = if_b.rdata0;
        mon_d1 = if_b.rdata1;
        if (q_b.size() > 0) if (q_b[0].due == cyc) begin
          mon_due = 1'b1;
          mon_e   = q_b.pop_front();
        end
      end
      if (mon_due) begin
        total++;
        if (mon_v !== (mon_e.id ? 2'b10 : 2'b01) ||
            (mon_e.id ? mon_d1 : mon_d0) !== mon_e.data) begin
          bad++;
          $display("FAIL rd_route lat%0d cyc=%0d rvalid{1,0}=%b rdata=%h required rvalid{1,0}=%b rdata=%h",
                   d + 1, cyc, mon_v, mon_e.id ? mon_d1 : mon_d0,
                   mon_e.id ? 2'b10 : 2'b01, mon_e.data);
        end
      end else if (mon_v !== 2'b00) begin
        total++;
        bad++;
        $display("FAIL spurious_rvalid lat%0d cyc=%0d rvalid{1,0}=%b required 00", d + 1, cyc, mon_v);
      end
    end
  end

  task automatic drive(input logic r0, input logic l0, input logic w0, input logic [AW-1:0] a0,
                       input logic r1, input logic l1, input logic w1, input logic [AW-1:0] a1);
    if_a.req0 = r0; if_a.lock0 = l0; if_a.we0 = w0; if_a.addr0 = a0;
    if_a.req1 = r1; if_a.lock1 = l1; if_a.we1 = w1; if_a.addr1 = a1;
    if_a.byteen0 = 4'h3; if_a.byteen1 = 4'hC;
    if_a.wdata0 = {16'hC0DE, a0}; if_a.wdata1 = {16'hBEEF, a1};
    if_b.req0 = r0; if_b.lock0 = l0; if_b.we0 = w0; if_b.addr0 = a0;
    if_b.req1 = r1; if_b.lock1 = l1; if_b.we1 = w1; if_b.addr1 = a1;
    if_b.byteen0 = 4'h3; if_b.byteen1 = 4'hC;
    if_b.wdata0 = {16'hC0DE, a0}; if_b.wdata1 = {16'hBEEF, a1};
  endtask

  task automatic push_rd(input logic id, input logic [AW-1:0] a);
    q_a.push_back('{due: cyc + 1, id: id, data: pattern(a)});
    q_b.push_back('{due: cyc + 2, id: id, data: pattern(a)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, 0, 0, '0, 0, 0, 0, '0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 16'h1234, 1, 1, 0, 16'h5678);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({if_a.gnt0, if_a.gnt1, if_a.mem_ren, if_a.mem_wen, if_a.rvalid0, if_a.rvalid1} !== 6'b0 ||
        {if_b.gnt0, if_b.gnt1, if_b.mem_ren, if_b.mem_wen, if_b.rvalid0, if_b.rvalid1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl a=%b b=%b required 000000",
               {if_a.gnt0, if_a.gnt1, if_a.mem_ren, if_a.mem_wen, if_a.rvalid0, if_a.rvalid1},
               {if_b.gnt0, if_b.gnt1, if_b.mem_ren, if_b.mem_wen, if_b.rvalid0, if_b.rvalid1});
    end
    total++;
    if ({if_a.mem_addr, if_a.mem_byteen, if_a.mem_wdata} !== '0 ||
        {if_b.mem_addr, if_b.mem_byteen, if_b.mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_mem addr=%h be=%h wdata=%h required all zero",
               if_a.mem_addr, if_a.mem_byteen, if_a.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 16'h0010, 0, 0, 0, '0);
    #1;
    total++;
    if ({if_a.gnt1, if_a.gnt0} !== 2'b01 || {if_b.gnt1, if_b.gnt0} !== 2'b01 ||
        if_a.mem_ren !== 1'b1 || if_a.mem_wen !== 1'b0 ||
        if_a.mem_addr !== 16'h0010 || if_a.mem_byteen !== 4'hF) begin
      bad++;
      $display("FAIL single_read gnt{1,0}=%b ren=%b wen=%b addr=%h be=%h required 01 1 0 0010 f",
               {if_a.gnt1, if_a.gnt0}, if_a.mem_ren, if_a.mem_wen, if_a.mem_addr, if_a.mem_byteen);
    end
    push_rd(1'b0, 16'h0010);
    idle(3);
  endtask

  task automatic test_alternate_writes();
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 1, 16'h0020, 1, 0, 1, 16'h0030);
      #1;
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      total++;
      if ({if_a.gnt1, if_a.gnt0} !== exp_g || {if_b.gnt1, if_b.gnt0} !== exp_g ||
          if_a.mem_wen !== 1'b1 || if_a.mem_ren !== 1'b0 ||
          if_a.mem_wdata !== ((i % 2 == 1) ? 32'hBEEF0030 : 32'hC0DE0020) ||
          if_a.mem_byteen !== ((i % 2 == 1) ? 4'hC : 4'h3)) begin
        bad++;
        $display("FAIL alt_wr[%0d] gnt{1,0}=%b wen=%b wdata=%h be=%h required gnt=%b wen=1 wdata=%h",
                 i, {if_a.gnt1, if_a.gnt0}, if_a.mem_wen, if_a.mem_wdata, if_a.mem_byteen,
                 exp_g, (i % 2 == 1) ? 32'hBEEF0030 : 32'hC0DE0020);
      end
    end
    idle(1);
  endtask

  task automatic test_lock_release();
    logic [1:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 16'h0040, 1, 0, 0, 16'h0050);
      #1;
      exp_g = (i == 3) ? 2'b10 : 2'b01;
      total++;
      if ({if_a.gnt1, if_a.gnt0} !== exp_g || {if_b.gnt1, if_b.gnt0} !== exp_g ||
          if_a.mem_addr !== ((i == 3) ? 16'h0050 : 16'h0040)) begin
        bad++;
        $display("FAIL lock[%0d] gnt{1,0}=%b addr=%h required gnt=%b", i,
                 {if_a.gnt1, if_a.gnt0}, if_a.mem_addr, exp_g);
      end
      push_rd(i == 3, (i == 3) ? 16'h0050 : 16'h0040);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic          ids   [3];
    addrs[0] = 16'h0001; addrs[1] = 16'h0002; addrs[2] = 16'h0003;
    ids[0] = 1'b0; ids[1] = 1'b1; ids[2] = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ids[i]) drive(0, 0, 0, '0, 1, 0, 0, addrs[i]);
      else        drive(1, 0, 0, addrs[i], 0, 0, 0, '0);
      #1;
      total++;
      if ({if_b.gnt1, if_b.gnt0} !== (ids[i] ? 2'b10 : 2'b01) || if_b.mem_addr !== addrs[i]) begin
        bad++;
        $display("FAIL b2b[%0d] gnt{1,0}=%b addr=%h required gnt=%b addr=%h", i,
                 {if_b.gnt1, if_b.gnt0}, if_b.mem_addr, ids[i] ? 2'b10 : 2'b01, addrs[i]);
      end
      push_rd(ids[i], addrs[i]);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    drive(1, 0, 0, 16'h0061, 1, 0, 0, 16'h0062);
    #1;
    total++;
    if ({if_a.gnt1, if_a.gnt0} !== 2'b01) begin
      bad++;
      $display("FAIL rst_mid_pre gnt{1,0}=%b required 01", {if_a.gnt1, if_a.gnt0});
    end
    @(negedge clk);
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    total++;
    if ({if_a.gnt1, if_a.gnt0, if_b.gnt1, if_b.gnt0} !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid_gnt gnt a=%b b=%b required 00 00",
               {if_a.gnt1, if_a.gnt0}, {if_b.gnt1, if_b.gnt0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({if_a.gnt1, if_a.gnt0} !== 2'b01 || {if_b.gnt1, if_b.gnt0} !== 2'b01) begin
      bad++;
      $display("FAIL rst_mid_first gnt a=%b b=%b required 01",
               {if_a.gnt1, if_a.gnt0}, {if_b.gnt1, if_b.gnt0});
    end
    push_rd(1'b0, 16'h0061);
    idle(4);
  endtask

  task automatic test_owner_drop();
    logic [1:0] got  [4];
    logic [1:0] want [4];
    want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b01; want[3] = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0:       drive(0, 0, 1, 16'h0070, 1, 1, 1, 16'h0071);
        1:       drive(1, 1, 1, 16'h0070, 0, 0, 1, 16'h0071);
        default: drive(1, 0, 1, 16'h0070, 1, 0, 1, 16'h0071);
      endcase
      #1;
      got[i] = {if_a.gnt1, if_a.gnt0};
      total++;
      if (got[i] !== want[i] || {if_b.gnt1, if_b.gnt0} !== want[i]) begin
        bad++;
        $display("FAIL owner_drop[%0d] gnt{1,0}=%b required %b", i, got[i], want[i]);
      end
    end
    idle(2);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, '0);
    test_reset();
    test_single_read();
    test_alternate_writes();
    test_lock_release();
    test_back_to_back();
    test_reset_mid();
    test_owner_drop();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left a=%0d b=%0d required 0 0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblsram_port_arbiter.md
Name: ahblsram_port_arbiter

Overview:
- Two-requester arbiter that shares one fabric SRAM port (mem_ren/mem_wen/mem_addr/mem_byteen/mem_wdata/mem_rdata) of the AHB-Lite SRAM subsystem.
- Typical requesters: the AHB-Lite SRAM bridge and a DMA/init engine.
- Round-robin grant, optional lock for back-to-back beats with a starvation bound, and read-data routing back to the issuing requester after a fixed memory latency.

Parameters:
- MEM_AWIDTH, 16, SRAM word-address width.
- RD_LAT, 1, cycles from a granted read to valid mem_rdata; legal values 1 or 2 (2 matches PIPE=1 SRAM).
- MAX_LOCK, 8, maximum consecutive locked grants to one requester before a forced release; legal range 1..255.

Ports:
- HCLK  in  1  clock; all logic rising-edge.
- HRESETN  in  1  synchronous active-low reset.
- req0, req1  in  1 each  access request.
- lock0, lock1  in  1 each  keep grant on the next cycle; valid only with req.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  MEM_AWIDTH each  word address.
- byteen0, byteen1  in  4 each  byte enables (writes only).
- wdata0, wdata1  in  32 each  write data.
- gnt0, gnt1  out  1 each  access accepted this cycle.
- rvalid0, rvalid1  out  1 each  read data valid for that requester.
- rdata0, rdata1  out  32 each  read data; both wired to mem_rdata.
- mem_ren  out  1  SRAM read enable.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  MEM_AWIDTH  SRAM address.
- mem_byteen  out  4  SRAM byte enables.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data.

Behaviour:
- Clocking/reset (already decided): one clock, HCLK; reset HRESETN is synchronous and active-low.
- While HRESETN=0:
  - gnt0/1, mem_ren, mem_wen, rvalid0/1 are 0.
  - mem_addr, mem_byteen, mem_wdata are 0.
  - Registers clear: last_win=1 (requester 0 wins first), lock_owner=NONE, lock_cnt=0, read-tag pipeline empty.
- Grant is combinational in the request cycle. At most one gnt is high per cycle; a gnt is high only when its req is high.
- Arbitration FSM states:
  - FREE:
    - Only one req high -> that requester wins.
    - Both high -> the requester that is not last_win wins.
  - OWN0 / OWN1:
    - Owner's req high -> owner wins unconditionally.
    - Owner's req low -> arbitrate as in FREE in the same cycle (no bubble).
- State update each cycle with a winner W:
  - last_win<=W.
  - If lockW=1 and lock_cnt+1<MAX_LOCK: go to OWN_W, lock_cnt++.
  - Otherwise: go to FREE, lock_cnt<=0.
- No winner -> go to FREE, lock_cnt<=0.
- Forced release after MAX_LOCK: the next cycle arbitrates as in FREE, so with both requesting the other requester wins.
- Memory drive:
  - Winner's addr/byteen/wdata go to mem_* combinationally.
  - mem_wen = winner.we; mem_ren = ~winner.we.
  - No winner -> mem_* are 0.
  - mem_byteen is forced 4'hF on reads.
- Read routing:
  - A granted read pushes a {valid, id} tag into an RD_LAT-deep shift register.
  - rvalidN=1 exactly RD_LAT cycles after the grant cycle when the tag id=N.
  - Writes push an invalid tag.
  - Throughput is 1 access per cycle; back-to-back reads from alternating requesters each return in order.
- Reset mid-operation: in-flight read tags are discarded; no rvalid follows reset deassertion.
- Requester contract: req, lock, and payload are held until gnt. A payload change while ungranted is legal and takes effect immediately.
- lock asserted without req is ignored.

Decomposition:
- Shared package:
  - Requester ID type and NONE encoding.
  - FSM state encoding (FREE/OWN0/OWN1).
  - Tag type {valid, id}.
  - Legal RD_LAT range.
- One sub-module: ahblsram_rd_tag_pipe, a parameterised RD_LAT-deep tag shift register with synchronous clear.

Test Plan:
- Reset, then req0 read addr 0x0010, RD_LAT=1, mem_rdata=0xDEADBEEF -> gnt0 same cycle, mem_ren=1, mem_addr=0x0010, rvalid0=1 with rdata0=0xDEADBEEF next cycle; rvalid1 stays 0.
- req0 and req1 held high with writes, no lock, 4 cycles -> grants 0,1,0,1; mem_wen=1 every cycle; mem_wdata alternates wdata0/wdata1.
- req0+lock0 and req1 held high, MAX_LOCK=3 -> gnt0 for 3 cycles, then gnt1 on cycle 4.
- RD_LAT=2: reads req0 @0x1, req1 @0x2, req0 @0x3 on consecutive cycles -> rvalid0, rvalid1, rvalid0 on cycles 3, 4, 5 with matching data.
- Read granted, HRESETN low on the next cycle for 1 cycle -> no rvalid afterwards; the first grant after reset goes to req0 when both request.
- Owner OWN1 drops req1 while req0 is high -> gnt0 in that same cycle; the state moves to FREE or OWN0 per lock0.
